// File: rtl/inagu.sv
// Input-memory address generator: walks a two-level nested loop (inner stride, outer jump)
// and presents one read address per consumed cycle, ending with a one-cycle done pulse.
module inagu #(
  parameter int BDBANKA = 15,
  parameter int BCNT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [BDBANKA-1:0] baseaddr,
  input  logic [BCNT-1:0]    ilength,
  input  logic [BDBANKA-1:0] istride,
  input  logic [BCNT-1:0]    olength,
  input  logic [BDBANKA-1:0] ojump,
  output logic [BDBANKA-1:0] addrout,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  // Handshake: addrout is offered while valid=1; the consumer takes it in any cycle
  // with valid=1 and stall=0, and everything holds while stall=1.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [BDBANKA-1:0] addr_q, addr_d;
  logic [BCNT-1:0]    icnt_q, icnt_d;
  logic [BCNT-1:0]    ocnt_q, ocnt_d;
  logic [BCNT-1:0]    ilen_q, ilen_d;
  logic [BDBANKA-1:0] istride_q, istride_d;
  logic [BDBANKA-1:0] ojump_q, ojump_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      icnt_q    <= '0;
      ocnt_q    <= '0;
      ilen_q    <= '0;
      istride_q <= '0;
      ojump_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      icnt_q    <= icnt_d;
      ocnt_q    <= ocnt_d;
      ilen_q    <= ilen_d;
      istride_q <= istride_d;
      ojump_q   <= ojump_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    icnt_d    = icnt_q;
    ocnt_d    = ocnt_q;
    ilen_d    = ilen_q;
    istride_d = istride_q;
    ojump_d   = ojump_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ilen_d    = ilength;
          istride_d = istride;
          ojump_d   = ojump;
          addr_d    = baseaddr;
          icnt_d    = ilength;
          ocnt_d    = olength;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (icnt_q != '0) begin
            addr_d = addr_q + istride_q;
            icnt_d = icnt_q - 1'b1;
          end else if (ocnt_q != '0) begin
            // Inner loop wrapped: the outer jump replaces the stride for this step.
            addr_d = addr_q + ojump_q;
            icnt_d = ilen_q;
            ocnt_d = ocnt_q - 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addrout = addr_q;
  assign valid   = (state_q == RUN);
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_inagu.sv
// Self-checking bench for inagu: directed walks plus randomized walks compared against
// a closed-form address model held in an expected queue.
module tb_inagu;
  localparam int BDBANKA = 15;
  localparam int BCNT    = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stall;
  logic [BDBANKA-1:0] baseaddr;
  logic [BCNT-1:0]    ilength;
  logic [BDBANKA-1:0] istride;
  logic [BCNT-1:0]    olength;
  logic [BDBANKA-1:0] ojump;
  logic [BDBANKA-1:0] addrout;
  logic               valid;
  logic               busy;
  logic               done;

  logic [BDBANKA-1:0] exp_q[$];
  logic [BDBANKA-1:0] last_addr;
  int checks   = 0;
  int failures = 0;

  inagu #(.BDBANKA(BDBANKA), .BCNT(BCNT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .baseaddr(baseaddr), .ilength(ilength), .istride(istride),
    .olength(olength), .ojump(ojump),
    .addrout(addrout), .valid(valid), .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: address at outer o, inner i = base + o*(ilen*istride + ojump) + i*istride.
  task automatic push_walk(input logic [BDBANKA-1:0] b, input int il,
                           input logic [BDBANKA-1:0] is, input int ol,
                           input logic [BDBANKA-1:0] oj);
    bit [31:0] a;
    for (int o = 0; o <= ol; o++)
      for (int i = 0; i <= il; i++) begin
        a = 32'(b) + 32'(o) * (32'(il) * 32'(is) + 32'(oj)) + 32'(i) * 32'(is);
        exp_q.push_back(a[BDBANKA-1:0]);
      end
  endtask

  task automatic drive_cfg(input logic [BDBANKA-1:0] b, input int il,
                           input logic [BDBANKA-1:0] is, input int ol,
                           input logic [BDBANKA-1:0] oj);
    baseaddr = b;
    ilength  = BCNT'(il);
    istride  = is;
    olength  = BCNT'(ol);
    ojump    = oj;
  endtask

  // Called at posedge+1; leaves the DUT with start pulsed for exactly one edge.
  task automatic issue_start(input logic [BDBANKA-1:0] b, input int il,
                             input logic [BDBANKA-1:0] is, input int ol,
                             input logic [BDBANKA-1:0] oj);
    push_walk(b, il, is, ol, oj);
    drive_cfg(b, il, is, ol, oj);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consumes the expected queue; stall_mask bit n forces a stall on valid cycle n.
  task automatic drain(input logic [31:0] stall_mask, input int stall_pct, input bit poke);
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      stall = (n < 32 && stall_mask[n]) || ($urandom_range(99) < stall_pct);
      if (poke) begin
        start = 1'($urandom_range(1));
        drive_cfg(BDBANKA'($urandom), $urandom_range(3), BDBANKA'($urandom),
                  $urandom_range(3), BDBANKA'($urandom));
      end
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || addrout !== exp_q[0]) begin
        failures++;
        $display("FAIL walk_addr: cycle %0d addrout=%h valid=%b busy=%b, expected addrout=%h valid=1 busy=1",
                 n, addrout, valid, busy, exp_q[0]);
      end
      @(posedge clk); #1;
      if (!stall) last_addr = exp_q.pop_front();
      n++;
    end
    stall = 1'b0;
    start = 1'b0;
    if (n >= 2000) begin
      failures++;
      $display("FAIL walk_timeout: %0d addresses never consumed, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // First IDLE cycle after the last consumption, then the cycle after it.
  task automatic check_done();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || addrout !== last_addr) begin
      failures++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b addrout=%h, expected done=1 valid=0 busy=0 addrout=%h",
               done, valid, busy, addrout, last_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || addrout !== last_addr) begin
      failures++;
      $display("FAIL done_width: done=%b valid=%b addrout=%h, expected done=0 valid=0 addrout=%h",
               done, valid, addrout, last_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    drive_cfg('0, 0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (addrout !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: addrout=%h valid=%b busy=%b done=%b, expected all 0",
               addrout, valid, busy, done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Abandon a walk mid-RUN with an asynchronous reset.
    issue_start(15'h0123, 5, 15'h0001, 2, 15'h0010);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (addrout !== '0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: addrout=%h valid=%b busy=%b done=%b, expected all 0",
               addrout, valid, busy, done);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || valid !== 1'b0 || addrout !== '0) begin
        failures++;
        $display("FAIL reset_no_done: cycle %0d done=%b valid=%b addrout=%h, expected 0 0 0000",
                 k, done, valid, addrout);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simple_walk();
    issue_start(15'h0100, 3, 15'h0001, 0, 15'h0000);
    drain(32'h0, 0, 1'b0);
    check_done();
  endtask

  task automatic test_nested_walk();
    issue_start(15'h0010, 1, 15'h0004, 2, 15'h0020);
    drain(32'h0, 0, 1'b0);
    check_done();
  endtask

  task automatic test_stall();
    issue_start(15'h0100, 3, 15'h0001, 0, 15'h0000);
    drain(32'h6, 0, 1'b0);
    check_done();
  endtask

  task automatic test_wrap();
    issue_start(15'h7FFE, 3, 15'h0001, 0, 15'h0000);
    drain(32'h0, 0, 1'b0);
    check_done();
    issue_start(15'h0002, 3, 15'h7FFF, 0, 15'h0000);
    drain(32'h0, 0, 1'b0);
    check_done();
  endtask

  task automatic test_back_to_back();
    // Random start/config pokes during RUN must be ignored.
    issue_start(15'h0200, 2, 15'h0003, 1, 15'h0100);
    drain(32'h0, 20, 1'b1);
    // Start in the done cycle: single-address walk follows immediately.
    push_walk(15'h0555, 0, 15'h0007, 0, 15'h0009);
    drive_cfg(15'h0555, 0, 15'h0007, 0, 15'h0009);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: done=%b valid=%b, expected done=1 valid=0", done, valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    drain(32'h0, 0, 1'b0);
    check_done();
  endtask

  task automatic test_random();
    for (int w = 0; w < 12; w++) begin
      issue_start(BDBANKA'($urandom), $urandom_range(5), BDBANKA'($urandom),
                  $urandom_range(4), BDBANKA'($urandom));
      drain(32'h0, 30, 1'b1);
      check_done();
    end
  endtask

  initial begin
    last_addr = '0;
    test_reset();
    test_simple_walk();
    test_nested_walk();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
